// File: rtl/pico_io_sequencer.sv
// pico_io_sequencer: plays operand sets onto in_bus with io_handshake pulses,
// samples out_bus after each set and tallies matches against an expected table.
module pico_io_sequencer #(
    parameter int N = 8,
    parameter int NumOps = 2,
    parameter int NumSets = 2,
    parameter logic [NumSets*NumOps*N-1:0] OPERANDS = {8'h8B, 8'hCE, 8'h55, 8'h22},
    parameter logic [NumSets*N-1:0] EXPECTED = '0,
    parameter int SetupCycles = 2,
    parameter int HoldCycles = 3,
    parameter int GapCycles = 2,
    parameter int ResultCycles = 20,
    localparam int CW = $clog2(NumSets + 1)
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  out_bus,
    output logic [N-1:0]  in_bus,
    output logic          io_handshake,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pass_count,
    output logic [CW-1:0] fail_count,
    output logic [N-1:0]  last_result
);
    localparam int M0 = SetupCycles > HoldCycles ? SetupCycles : HoldCycles;
    localparam int M1 = GapCycles > ResultCycles ? GapCycles : ResultCycles;
    localparam int TW = $clog2((M0 > M1 ? M0 : M1) + 1);
    localparam int OW = $clog2(NumOps + 1);

    typedef enum logic [3:0] {
        IDLE, SETUP, HS_HIGH, HS_LOW, WAIT_RES, CHECK, ACK_HIGH, ACK_LOW, DONE
    } state_t;

    state_t state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [CW-1:0] set_idx, set_nx, pass_nx, fail_nx;
    logic [OW-1:0] op_idx, op_nx;
    logic [N-1:0] in_nx, last_nx;
    logic hs_nx, busy_nx, done_nx;

    function automatic logic [N-1:0] operand(input int s, input int k);
        return OPERANDS[(s*NumOps+k)*N +: N];
    endfunction

    // Timer counts the remaining cycles of the current state, down to zero.
    function automatic logic [TW-1:0] load(input state_t s);
        return s == SETUP ? TW'(SetupCycles - 1) :
               (s == HS_HIGH || s == ACK_HIGH) ? TW'(HoldCycles - 1) :
               (s == HS_LOW || s == ACK_LOW) ? TW'(GapCycles - 1) :
               s == WAIT_RES ? TW'(ResultCycles - 1) : '0;
    endfunction

    always_comb begin
        state_nx = state;
        timer_nx = timer == '0 ? '0 : timer - 1'b1;
        set_nx = set_idx;
        op_nx = op_idx;
        in_nx = in_bus;
        hs_nx = io_handshake;
        busy_nx = busy;
        done_nx = done;
        pass_nx = pass_count;
        fail_nx = fail_count;
        last_nx = last_result;
        if (abort) begin
            state_nx = IDLE;
            hs_nx = 1'b0;
            in_nx = '0;
            busy_nx = 1'b0;
            done_nx = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state_nx = SETUP;
                    pass_nx = '0;
                    fail_nx = '0;
                    done_nx = 1'b0;
                    busy_nx = 1'b1;
                    set_nx = '0;
                    op_nx = '0;
                    in_nx = operand(0, 0);
                end
                SETUP: if (timer == '0) begin
                    state_nx = HS_HIGH;
                    hs_nx = 1'b1;
                end
                HS_HIGH, ACK_HIGH: if (timer == '0) begin
                    state_nx = state == HS_HIGH ? HS_LOW : ACK_LOW;
                    hs_nx = 1'b0;
                end
                HS_LOW: if (timer == '0) begin
                    if (int'(op_idx) < NumOps - 1) begin
                        state_nx = SETUP;
                        op_nx = op_idx + 1'b1;
                        in_nx = operand(int'(set_idx), int'(op_idx) + 1);
                    end else state_nx = WAIT_RES;
                end
                WAIT_RES: if (timer == '0) state_nx = CHECK;
                CHECK: begin
                    state_nx = ACK_HIGH;
                    hs_nx = 1'b1;
                    last_nx = out_bus;
                    if (out_bus == EXPECTED[int'(set_idx)*N +: N]) pass_nx = pass_count + 1'b1;
                    else fail_nx = fail_count + 1'b1;
                end
                ACK_LOW: if (timer == '0) begin
                    if (int'(set_idx) < NumSets - 1) begin
                        state_nx = SETUP;
                        set_nx = set_idx + 1'b1;
                        op_nx = '0;
                        in_nx = operand(int'(set_idx) + 1, 0);
                    end else begin
                        state_nx = DONE;
                        busy_nx = 1'b0;
                        done_nx = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        if (state_nx != state) timer_nx = load(state_nx);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            timer <= '0;
            set_idx <= '0;
            op_idx <= '0;
            in_bus <= '0;
            io_handshake <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
            last_result <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            set_idx <= set_nx;
            op_idx <= op_nx;
            in_bus <= in_nx;
            io_handshake <= hs_nx;
            busy <= busy_nx;
            done <= done_nx;
            pass_count <= pass_nx;
            fail_count <= fail_nx;
            last_result <= last_nx;
        end
    end
endmodule
